// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 32x32 register file with one write port and two registered read ports.
// Register 0 reads as zero; BYPASS selects write-first or read-first on an address collision.
module reg_file_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] d,
  input  logic              re1,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] q1,
  output logic              v1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] q2,
  output logic              v2
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  wen;
  logic [DATA_W-1:0] q1_d, q1_q, q2_d, q2_q;
  logic              v1_d, v1_q, v2_d, v2_q;
  logic              byp1, byp2;
  always_comb begin
    wen = '0;
    wen[wa] = we;
    wen[0] = 1'b0;
    for (int i = 0; i < DEPTH; i++) regs_d[i] = wen[i] ? d : regs_q[i];
    byp1 = (BYPASS != 0) && we && (wa == ra1);
    byp2 = (BYPASS != 0) && we && (wa == ra2);
    q1_d = !re1 ? q1_q : (ra1 == '0) ? '0 : byp1 ? d : regs_q[ra1];
    q2_d = !re2 ? q2_q : (ra2 == '0) ? '0 : byp2 ? d : regs_q[ra2];
    v1_d = re1;
    v2_d = re2;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      q1_q <= '0;
      q2_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      q1_q <= q1_d;
      q2_q <= q2_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end
  assign q1 = q1_q;
  assign q2 = q2_q;
  assign v1 = v1_q;
  assign v2 = v2_q;
endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- MIPS32 general-purpose register file: 32 x 32-bit registers, one write port, two registered read ports.
- Sits between instruction decode and the ALU in the datapath.
- It is the reading end of the 32-bit register storage. The write side uses the same d/we/clk convention as the existing 32-bit register; read data is returned one cycle after the request, with a valid flag.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of all data ports
- ADDR_W, 5, register address width; depth is 2**ADDR_W
- BYPASS, 1, 1 = a read of an address written in the same cycle returns the new data; 0 = it returns the old contents

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- we  input  1  write enable
- wa  input  ADDR_W  write address
- d  input  DATA_W  write data
- re1  input  1  read request, port 1
- ra1  input  ADDR_W  read address, port 1
- q1  output  DATA_W  read data, port 1 (registered)
- v1  output  1  q1 valid
- re2  input  1  read request, port 2
- ra2  input  ADDR_W  read address, port 2
- q2  output  DATA_W  read data, port 2 (registered)
- v2  output  1  q2 valid

Behaviour:
- Reset:
  - One clock, clk. Reset rst is asynchronous and active-high.
  - While rst=1: all 32 registers = 0, q1 = q2 = 0, v1 = v2 = 0, immediately and independent of clk.
  - Deassertion is synchronised by the integrating design. The first active edge after deassertion behaves normally.
- Write:
  - On a rising clk edge with we=1 and wa!=0: reg[wa] <= d.
  - A write with wa=0 is discarded. reg[0] always reads 0.
  - we=0: no register changes.
- Read, per port n (independent and identical):
  - On a rising edge with ren=1: qn <= value(ran), vn <= 1.
  - On a rising edge with ren=0: vn <= 0 and qn holds its previous value.
  - Latency is exactly 1 cycle. There is no back-pressure; a new request is accepted every cycle.
- value(a):
  - a==0: returns 0, always, including when wa==0 with we=1.
  - BYPASS=1 and we=1 and wa==a: returns d (write-first).
  - Otherwise returns reg[a] as it was before the edge (read-first when BYPASS=0).
- Simultaneous events:
  - Both ports reading the same address: both return identical data.
  - Both ports reading the write address: the bypass rule applies to each port.
- Reset mid-operation: an in-flight read is lost and v1/v2 drop to 0 immediately. No partial write occurs; a write on the same edge as the rst assertion is not performed.
- qn is only meaningful while vn=1. It must still be deterministic (held value) when vn=0.
- Storage is an array of DATA_W flops with a per-register enable, decoded from we and wa. The decode is one-hot, with bit 0 suppressed.

Test Plan:
- Reset:
  - Write 0xDEADBEEF to r5, then assert rst for 3 ns between edges. Expect q1/q2/v1/v2 = 0 at once.
  - Read r5 after release. Expect q1=0x00000000 and v1=1 one cycle after the request.
- Zero register: we=1, wa=0, d=0xFFFFFFFF, then re1=1, ra1=0. Expect q1=0x00000000, v1=1.
- Latency/valid:
  - Write r7=0x12345678.
  - Next cycle: re1=1, ra1=7; re2=1, ra2=7. Expect q1=q2=0x12345678, v1=v2=1 on the following edge.
  - Following cycle: re1=re2=0. Expect v1=v2=0, q1/q2 hold 0x12345678.
- Bypass:
  - r3=0x00000011. In one cycle drive we=1, wa=3, d=0x00000022 together with re1=1, ra1=3.
  - BYPASS=1: expect q1=0x00000022.
  - BYPASS=0: expect q1=0x00000011; a read the next cycle gives 0x00000022.
- Back-to-back sweep:
  - Write r1..r31 with value = index * 0x01010101.
  - Read port 1 ascending and port 2 descending, every cycle without gaps. Expect every result correct with v=1 continuously.
- Reset mid-read: issue re1=1, ra1=9 with r9 nonzero, and assert rst before the next edge. Expect v1=0, q1=0, and r9=0 on a later read.
